// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiply / multiply-accumulate unit:
// function-field values, FSM states and operation kinds.
package mul_pkg;

   localparam logic [5:0] MFHI  = 6'h10;
   localparam logic [5:0] MTHI  = 6'h11;
   localparam logic [5:0] MFLO  = 6'h12;
   localparam logic [5:0] MTLO  = 6'h13;
   localparam logic [5:0] MULT  = 6'h18;
   localparam logic [5:0] MULTU = 6'h19;

   localparam logic [5:0] MADD  = 6'h00;
   localparam logic [5:0] MADDU = 6'h01;
   localparam logic [5:0] MUL   = 6'h02;
   localparam logic [5:0] MSUB  = 6'h04;
   localparam logic [5:0] MSUBU = 6'h05;

   typedef enum logic [1:0] {IDLE, ITER, FINISH, DONE} mul_state_t;
   typedef enum logic [1:0] {K_MULT, K_MADD, K_MSUB, K_MUL} mul_kind_t;

endpackage

// File: rtl/mul_iter.sv
// One multiply step: 32 x ITER_BITS unsigned partial product, shifted into
// its byte lane and added to the 64-bit running product.
module mul_iter #(
   parameter int ITER_BITS = 8
) (
   input  logic [63:0]          i_acc,
   input  logic [31:0]          i_mag_a,
   input  logic [ITER_BITS-1:0] i_mag_b_part,
   input  logic [1:0]           i_idx,
   output logic [63:0]          o_sum
);

   logic [31+ITER_BITS:0] w_pp;
   logic [5:0]            w_shift;

   assign w_pp    = (32+ITER_BITS)'(i_mag_a) * (32+ITER_BITS)'(i_mag_b_part);
   assign w_shift = 6'(i_idx) * 6'(ITER_BITS);
   assign o_sum   = i_acc + (64'(w_pp) << w_shift);

endmodule

// File: rtl/mul_acc_unit.sv
// Iterative 32x32 multiply / multiply-accumulate with HI/LO registers.
// Four sign-magnitude iterations, one FINISH step applying sign and accumulate.
module mul_acc_unit
   import mul_pkg::*;
#(
   parameter int ITER_BITS = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ALUOp,
   input  logic        MULOp,
   input  logic        ACCEn,
   input  logic        MULSelB,
   input  logic        Flush,
   input  logic [5:0]  Func,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Result,
   output logic        Stall,
   output logic        Busy
);

   mul_state_t r_state, w_state_nxt;
   mul_kind_t  r_kind, w_kind;
   logic [1:0]  r_cnt;
   logic        r_neg;
   logic [31:0] r_mag_a, r_mag_b;
   logic [63:0] r_prod;
   logic [31:0] r_hi, r_lo, r_mulres;

   logic w_is_mul_fn, w_req, w_mul_class, w_signed, w_issue, w_idle;
   logic w_own_done, w_rd_hi, w_rd_lo, w_wr_hi, w_wr_lo, w_neg, w_fin;
   logic [31:0] w_mag_a, w_mag_b;
   logic [63:0] w_it_acc, w_it_sum, w_p;
   logic [31:0] w_it_a;
   logic [ITER_BITS-1:0] w_it_b;
   logic [1:0]  w_it_idx;

   assign w_is_mul_fn = MULOp & (Func == MUL);
   assign w_req       = (ACCEn | w_is_mul_fn) & ~Flush;
   assign w_mul_class = (ALUOp & ((Func == MULT) | (Func == MULTU))) |
                        (MULOp & ((Func == MADD) | (Func == MADDU) | (Func == MUL) |
                                  (Func == MSUB) | (Func == MSUBU)));
   assign w_signed    = (ALUOp & (Func == MULT)) |
                        (MULOp & ((Func == MADD) | (Func == MSUB) | (Func == MUL)));
   assign w_idle      = (r_state == IDLE);
   assign w_issue     = w_req & w_mul_class & w_idle;
   assign w_own_done  = (r_state == DONE) & w_is_mul_fn;
   assign w_rd_hi     = w_req & ALUOp & (Func == MFHI);
   assign w_rd_lo     = w_req & ALUOp & (Func == MFLO);
   assign w_wr_hi     = w_req & ALUOp & ~MULSelB & (Func == MTHI);
   assign w_wr_lo     = w_req & ALUOp & ~MULSelB & (Func == MTLO);

   assign w_mag_a = (w_signed & A[31]) ? (~A + 32'd1) : A;
   assign w_mag_b = (w_signed & B[31]) ? (~B + 32'd1) : B;
   assign w_neg   = w_signed & (A[31] ^ B[31]);

   always_comb begin
      w_kind = K_MULT;
      if (MULOp) begin
         case (Func)
            MADD, MADDU: w_kind = K_MADD;
            MSUB, MSUBU: w_kind = K_MSUB;
            MUL:         w_kind = K_MUL;
            default:     w_kind = K_MULT;
         endcase
      end
   end

   // Iteration 0 runs on the live operands during the issue edge
   assign w_it_acc = w_idle ? 64'd0 : r_prod;
   assign w_it_a   = w_idle ? w_mag_a : r_mag_a;
   assign w_it_b   = w_idle ? w_mag_b[ITER_BITS-1:0] : r_mag_b[r_cnt*ITER_BITS +: ITER_BITS];
   assign w_it_idx = w_idle ? 2'd0 : r_cnt;

   mul_iter #(.ITER_BITS(ITER_BITS)) u_iter (
      .i_acc       (w_it_acc),
      .i_mag_a     (w_it_a),
      .i_mag_b_part(w_it_b),
      .i_idx       (w_it_idx),
      .o_sum       (w_it_sum)
   );

   assign w_p   = r_neg ? (~r_prod + 64'd1) : r_prod;
   assign w_fin = (r_state == FINISH) & ~(Flush & (r_kind == K_MUL));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   if (w_issue) w_state_nxt = ITER;
         ITER:   if (Flush && r_kind == K_MUL) w_state_nxt = IDLE;
                 else if (r_cnt == 2'd3)      w_state_nxt = FINISH;
         FINISH: if (r_kind == K_MUL && !Flush) w_state_nxt = DONE;
                 else                           w_state_nxt = IDLE;
         DONE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_kind   <= K_MULT;
         r_cnt    <= 2'd0;
         r_neg    <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_prod   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mulres <= '0;
      end else begin
         if (w_issue) begin
            r_kind  <= w_kind;
            r_neg   <= w_neg;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_prod  <= w_it_sum;
            r_cnt   <= 2'd1;
         end else if (r_state == ITER) begin
            r_prod <= w_it_sum;
            r_cnt  <= r_cnt + 2'd1;
         end
         if (w_fin) begin
            case (r_kind)
               K_MULT:  {r_hi, r_lo} <= w_p;
               K_MADD:  {r_hi, r_lo} <= {r_hi, r_lo} + w_p;
               K_MSUB:  {r_hi, r_lo} <= {r_hi, r_lo} - w_p;
               default: r_mulres <= w_p[31:0];
            endcase
         end else if (w_idle) begin
            if (w_wr_hi) r_hi <= A;
            if (w_wr_lo) r_lo <= A;
         end
      end
   end

   // The MUL still parked in EX collects its result in DONE without stalling
   assign Stall = w_req & ((w_issue & (w_kind == K_MUL)) | (~w_idle & ~w_own_done));
   assign Busy  = ~w_idle;

   always_comb begin
      Result = '0;
      if (w_req & w_own_done)  Result = r_mulres;
      else if (w_idle & w_rd_hi) Result = r_hi;
      else if (w_idle & w_rd_lo) Result = r_lo;
   end

endmodule

// File: tb/tb_mul_acc_unit.sv
// Directed-vector bench for mul_acc_unit: HI/LO results, stall timing,
// flush and asynchronous reset behaviour.
module tb_mul_acc_unit;
   import mul_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ALUOp, MULOp, ACCEn, MULSelB, Flush;
   logic [5:0]  Func;
   logic [31:0] A, B;
   logic [31:0] Result;
   logic        Stall, Busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   mul_acc_unit #(.ITER_BITS(8)) dut (
      .clock  (clock),
      .reset  (reset),
      .ALUOp  (ALUOp),
      .MULOp  (MULOp),
      .ACCEn  (ACCEn),
      .MULSelB(MULSelB),
      .Flush  (Flush),
      .Func   (Func),
      .A      (A),
      .B      (B),
      .Result (Result),
      .Stall  (Stall),
      .Busy   (Busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle();
      ALUOp = 1'b0; MULOp = 1'b0; ACCEn = 1'b0; MULSelB = 1'b1;
      Flush = 1'b0; Func = 6'h3f; A = '0; B = '0;
      #1;
   endtask

   // MUL is requested through MULOp alone (ACCEn low); everything else via ACCEn
   task automatic drive_op(input logic alu, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
      ALUOp   = alu;
      MULOp   = ~alu;
      Func    = f;
      A       = a;
      B       = b;
      Flush   = 1'b0;
      ACCEn   = ~(~alu & (f == MUL));
      MULSelB = ~(alu & ((f == MTHI) | (f == MTLO)));
      #1;
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      drive_op(1'b1, MFHI, '0, '0);
      check_eq({tag, ".hi"}, Result, hi);
      next_cyc();
      drive_op(1'b1, MFLO, '0, '0);
      check_eq({tag, ".lo"}, Result, lo);
      next_cyc();
      drive_idle();
   endtask

   task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
      drive_op(1'b1, MTHI, hi, '0);
      next_cyc();
      drive_op(1'b1, MTLO, lo, '0);
      next_cyc();
      drive_idle();
   endtask

   // Issue a non-blocking op and idle until T+5
   task automatic issue(input logic alu, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
      drive_op(alu, f, a, b);
      next_cyc();
      drive_idle();
      repeat (4) next_cyc();
   endtask

   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
      int n;
      n = 0;
      drive_op(1'b0, MUL, a, b);
      while (Stall && n < 10) begin
         n++;
         next_cyc();
      end
      check_eq({tag, ".stall_cycles"}, n, 5);
      check_eq({tag, ".stall_done"}, Stall, 1'b0);
      check_eq({tag, ".result"}, Result, exp);
      next_cyc();
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int n;
      drive_idle();
      reset = 1'b1;
      #1;
      check_eq("rst.result", Result, '0);
      check_eq("rst.stall", Stall, 1'b0);
      check_eq("rst.busy", Busy, 1'b0);
      next_cyc();
      next_cyc();
      reset = 1'b0;
      next_cyc();
      read_hilo("rst", 32'h0, 32'h0);

      // MULT 7 x -3 = -21
      drive_op(1'b1, MULT, 32'd7, 32'hFFFFFFFD);
      check_eq("mult.stall_issue", Stall, 1'b0);
      next_cyc();
      drive_idle();
      check_eq("mult.busy_t1", Busy, 1'b1);
      repeat (3) next_cyc();
      check_eq("mult.busy_t4", Busy, 1'b1);
      next_cyc();
      check_eq("mult.busy_t5", Busy, 1'b0);
      read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

      // MULTU then MFLO back-to-back: 0x12345 * 0x10000 = 0x1_2345_0000
      drive_op(1'b1, MULTU, 32'h00012345, 32'h00010000);
      next_cyc();
      drive_op(1'b1, MFLO, '0, '0);
      n = 0;
      while (Stall && n < 10) begin
         n++;
         next_cyc();
      end
      check_eq("mflo.stall_cycles", n, 4);
      check_eq("mflo.result", Result, 32'h23450000);
      next_cyc();
      drive_idle();
      read_hilo("multu", 32'h00000001, 32'h23450000);

      issue(1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      read_hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);

      // MUL leaves HI/LO alone
      write_hilo(32'h12345678, 32'h9ABCDEF0);
      do_mul("mul_min", 32'h80000000, 32'h80000000, 32'h00000000);
      read_hilo("mul_hilo", 32'h12345678, 32'h9ABCDEF0);
      do_mul("mul_neg", 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB);
      do_mul("mul_nn", 32'hFFFFFFF9, 32'hFFFFFFFA, 32'd42);

      // Accumulate wrap and signed accumulate
      write_hilo(32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(1'b0, MADDU, 32'd1, 32'd1);
      read_hilo("maddu_wrap", 32'h0, 32'h0);
      issue(1'b0, MSUB, 32'd0, 32'd5);
      read_hilo("msub_zero", 32'h0, 32'h0);
      issue(1'b0, MSUB, 32'd2, 32'd3);
      read_hilo("msub", 32'hFFFFFFFF, 32'hFFFFFFFA);
      issue(1'b0, MADD, 32'hFFFFFFFE, 32'd3);
      read_hilo("madd", 32'hFFFFFFFF, 32'hFFFFFFF4);

      // Flush aborts an in-flight MUL
      drive_op(1'b0, MUL, 32'd3, 32'd4);
      check_eq("mulflush.stall_t0", Stall, 1'b1);
      next_cyc();
      next_cyc();
      Flush = 1'b1;
      #1;
      check_eq("mulflush.stall_t2", Stall, 1'b0);
      check_eq("mulflush.result_t2", Result, '0);
      next_cyc();
      drive_idle();
      check_eq("mulflush.busy_t3", Busy, 1'b0);
      check_eq("mulflush.stall_t3", Stall, 1'b0);
      read_hilo("mulflush", 32'hFFFFFFFF, 32'hFFFFFFF4);

      // Flush does not abort an in-flight MULTU
      drive_op(1'b1, MULTU, 32'h100, 32'h100);
      next_cyc();
      next_cyc();
      drive_op(1'b1, MFHI, '0, '0);
      Flush = 1'b1;
      #1;
      check_eq("multflush.stall_t2", Stall, 1'b0);
      check_eq("multflush.result_t2", Result, '0);
      next_cyc();
      drive_idle();
      check_eq("multflush.busy_t3", Busy, 1'b1);
      next_cyc();
      next_cyc();
      check_eq("multflush.busy_t5", Busy, 1'b0);
      read_hilo("multflush", 32'h0, 32'h00010000);

      // Reset in the middle of MADD
      drive_op(1'b0, MADD, 32'd5, 32'd5);
      next_cyc();
      next_cyc();
      drive_idle();
      reset = 1'b1;
      #1;
      check_eq("midrst.busy", Busy, 1'b0);
      check_eq("midrst.stall", Stall, 1'b0);
      check_eq("midrst.result", Result, '0);
      next_cyc();
      reset = 1'b0;
      next_cyc();
      read_hilo("midrst", 32'h0, 32'h0);
      issue(1'b1, MULTU, 32'd3, 32'd4);
      read_hilo("postrst", 32'h0, 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mul_acc_unit.md
# mul_acc_unit

Iterative 32×32 multiply / multiply-accumulate unit with architectural HI/LO registers. It sits in the execute stage directly downstream of the execute control logic and consumes its ACCEn and MULSelB outputs. Its Result feeds the OutSel=2'b10 leg of the execute result mux. It interlocks the pipeline through Stall when a request needs an unfinished multiply.

## Interface
Parameters:
- ITER_BITS, 8, multiplier bits consumed per iteration. Fixed at 8, giving 4 iterations.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ALUOp  in  1  SPECIAL opcode space; Func decoded as MFHI/MTHI/MFLO/MTLO/MULT/MULTU
- MULOp  in  1  SPECIAL2 opcode space; Func decoded as MADD/MADDU/MUL/MSUB/MSUBU
- ACCEn  in  1  HI/LO-class request from execute control
- MULSelB  in  1  0 = MTHI/MTLO; write A into HI/LO
- Flush  in  1  kill the instruction currently in EX
- Func  in  6  function field
- A, B  in  32  rs / rt operands
- Result  out  32  MFHI/MFLO/MUL result
- Stall  out  1  hold the pipeline; comb
- Busy  out  1  iteration in flight

## Operation
- Req = (ACCEn | (MULOp & Func==MUL)) & !Flush.
- Issue condition: Req, state IDLE, op is multiply-class (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL).
- On issue, latch the sign-magnitude operands, Kind and NegFlag, clear Prod, and perform iteration 0 in the same edge.
- Signed ops take magnitudes |A| and |B|. |−2^31| = 0x80000000 as unsigned.
- NegFlag = A[31]^B[31] for signed ops, 0 for unsigned ops.
- Iteration i adds |A| × |B|[8i+7:8i] << 8i into a 64-bit Prod.
- FINISH step:
  - P = NegFlag ? −Prod : Prod.
  - MULT/MULTU: {HI,LO}=P.
  - MADD/MADDU: {HI,LO}+=P. MSUB/MSUBU: {HI,LO}−=P. Both wrap mod 2^64.
  - MUL: MulRes=P[31:0]. HI/LO are not modified.
- States and transitions:
  - IDLE → ITER on issue.
  - ITER holds count 1..3 → FINISH.
  - FINISH → IDLE, except MUL → DONE.
  - DONE → IDLE.
- MULT-class ops are non-blocking: Stall=0 in their issue cycle, and the pipeline advances.
- MUL is blocking: Stall=1 from its issue cycle until DONE. In DONE, Stall=0 and Result=MulRes.
- MFHI/MFLO/MTHI/MTLO or any new multiply op while state≠IDLE (excluding the owning MUL in DONE): Stall=1 until IDLE.
- MFHI/MFLO in IDLE: Result=HI/LO, no stall.
- MTHI/MTLO in IDLE: write A into HI/LO at the edge.
- Result=0 whenever there is no read or MUL completion.
- Flush:
  - suppresses issue in the same cycle;
  - aborts an in-flight MUL (state→IDLE next edge, MulRes untouched);
  - does NOT abort an in-flight MULT/MADD/MSUB, which has already retired from EX.

## Timing
- Reset values: HI=LO=0, Prod=0, MulRes=0, state IDLE, Busy=0, Stall=0, Result=0.
- Reset mid-operation abandons the op. HI/LO return to 0.
- Op presented in cycle T (IDLE):
  - iterations occur at the edges ending T, T+1, T+2, T+3;
  - FINISH occurs at the edge ending T+4;
  - HI/LO are visible from T+5.
- MUL at T: Stall=1 in T..T+4. At T+5, Stall=0 and Result valid.
- MFLO at T+1 after MULT at T: stalls in T+1..T+4, reads the new LO at T+5.
- Busy=1 in states ITER, FINISH and DONE.
- Stall is combinational from Req, Func, state and Flush, with no same-cycle dependence on Result.

## Structure
- Package mul_pkg holds:
  - Func constants MFHI=6'h10, MTHI=6'h11, MFLO=6'h12, MTLO=6'h13, MULT=6'h18, MULTU=6'h19;
  - MADD=6'h00, MADDU=6'h01, MUL=6'h02, MSUB=6'h04, MSUBU=6'h05;
  - mul_state_t {IDLE, ITER, FINISH, DONE};
  - mul_kind_t {K_MULT, K_MADD, K_MSUB, K_MUL}.
- Sub-module mul_iter: combinational 32×8 unsigned partial product, shifted and added to the 64-bit accumulator. It is instantiated once.

## Test plan
- MULT A=7, B=−3 (0xFFFFFFFD) at T → HI=0xFFFFFFFF and LO=0xFFFFFFEB at T+5; Stall=0 at T.
- MULT then MFLO back-to-back → Stall high for exactly 4 cycles, then Result=LO.
- MUL A=B=0x80000000 → Stall in T..T+4, Result=0x00000000 at T+5; HI/LO unchanged from the preloaded 0x12345678/0x9ABCDEF0.
- MTHI/MTLO preload HI=LO=0xFFFFFFFF, then MADDU 1×1 → HI=LO=0. Then MSUB 0×5 → HI/LO remain 0.
- Flush asserted at T+2 of a MUL → IDLE at T+3, Stall=0, HI/LO and MulRes unchanged. Flush at T+2 of a MULT → HI/LO still updated at T+5.
- reset pulsed at T+2 of MADD → all outputs at reset values immediately, HI=LO=0, and the next MULTU 3×4 gives LO=12.
